flush_sequencer: RTL and testbench

FLUSH_SEQUENCER -- requirements
Module: flush_sequencer

---
 rtl/flush_sequencer.sv | 85 ++++++++
 tb/tb_flush_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/flush_sequencer.sv
// flush_sequencer: sequences pipeline flush, LSB drain wait and IF redirect after a branch mispredict.
module flush_sequencer #(
  parameter int DRAIN_MAX = 15,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             mispredict,
  input  logic [31:0]      redirect_addr,
  input  logic             lsb_drain_done,
  output logic             if_flush,
  output logic             rob_flush,
  output logic             rs_flush,
  output logic             register_flush,
  output logic             cdb_flush,
  output logic             lsb_flush,
  output logic             predictor_flush,
  output logic             if_redirect,
  output logic [31:0]      addr_to_if,
  output logic             issue_stall,
  output logic             drain_timeout,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLUSH    = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;
  localparam logic [1:0] REDIRECT = 2'd3;
  localparam int DW = $clog2(DRAIN_MAX + 1);
  logic [1:0]    state;
  logic [31:0]   pc;
  logic [DW-1:0] drain_cnt;
  logic          flush;
  logic          drain_end;
  assign if_flush        = flush;
  assign rob_flush       = flush;
  assign rs_flush        = flush;
  assign register_flush  = flush;
  assign cdb_flush       = flush;
  assign lsb_flush       = flush;
  assign predictor_flush = flush;
  // leave DRAIN on acknowledge, or on the DRAIN_MAX-th cycle without one
  assign drain_end = lsb_drain_done || (drain_cnt == DW'(DRAIN_MAX - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= '0;
      drain_cnt     <= '0;
      flush         <= 1'b0;
      if_redirect   <= 1'b0;
      addr_to_if    <= '0;
      issue_stall   <= 1'b0;
      drain_timeout <= 1'b0;
      flush_count   <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: if (mispredict) begin
          pc          <= redirect_addr;
          flush_count <= &flush_count ? flush_count : flush_count + 1'b1;
          flush       <= 1'b1;
          issue_stall <= 1'b1;
          state       <= FLUSH;
        end
        FLUSH: begin
          flush     <= 1'b0;
          drain_cnt <= '0;
          state     <= DRAIN;
        end
        DRAIN: if (drain_end) begin
          if_redirect <= 1'b1;
          addr_to_if  <= pc;
          state       <= REDIRECT;
          if (!lsb_drain_done) drain_timeout <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt + 1'b1;
        end
        default: begin
          if_redirect <= 1'b0;
          issue_stall <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flush_sequencer.sv
// tb_flush_sequencer: scoreboard bench running a default and a CNT_W=4 instance side by side.
module tb_flush_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1, rdy = 1'b1, mispredict = 1'b0, done = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic [6:0] a_fl, b_fl;
  logic a_redir, b_redir, a_stall, b_stall, a_to, b_to;
  logic [31:0] a_addr, b_addr, e;
  logic [15:0] a_cnt;
  logic [3:0] b_cnt;
  int tests = 0, fails = 0, m16 = 0, m4 = 0;
  logic [31:0] sb[$];
  always #5 clk = ~clk;
  flush_sequencer u_a (
    .clk(clk), .rst(rst), .rdy(rdy), .mispredict(mispredict), .redirect_addr(redirect_addr),
    .lsb_drain_done(done), .if_flush(a_fl[6]), .rob_flush(a_fl[5]), .rs_flush(a_fl[4]),
    .register_flush(a_fl[3]), .cdb_flush(a_fl[2]), .lsb_flush(a_fl[1]), .predictor_flush(a_fl[0]),
    .if_redirect(a_redir), .addr_to_if(a_addr), .issue_stall(a_stall), .drain_timeout(a_to),
    .flush_count(a_cnt)
  );
  flush_sequencer #(.CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .rdy(rdy), .mispredict(mispredict), .redirect_addr(redirect_addr),
    .lsb_drain_done(done), .if_flush(b_fl[6]), .rob_flush(b_fl[5]), .rs_flush(b_fl[4]),
    .register_flush(b_fl[3]), .cdb_flush(b_fl[2]), .lsb_flush(b_fl[1]), .predictor_flush(b_fl[0]),
    .if_redirect(b_redir), .addr_to_if(b_addr), .issue_stall(b_stall), .drain_timeout(b_to),
    .flush_count(b_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input logic [6:0] fl, input logic st);
    chk({tag, "_fl"}, a_fl, fl);
    chk({tag, "_fl4"}, b_fl, fl);
    chk({tag, "_stall"}, a_stall, st);
    chk({tag, "_stall4"}, b_stall, st);
  endtask
  task automatic timeouts(input string tag, input logic exp);
    chk({tag, "_to"}, a_to, exp);
    chk({tag, "_to4"}, b_to, exp);
  endtask
  task automatic cnts(input string tag);
    chk({tag, "_cnt"}, a_cnt, m16);
    chk({tag, "_cnt4"}, b_cnt, m4);
  endtask
  task automatic mp(input logic [31:0] addr, input bit acc);
    mispredict = 1'b1;
    redirect_addr = addr;
    if (acc) begin
      sb.push_back(addr);
      m16 = m16 < 65535 ? m16 + 1 : m16;
      m4 = m4 < 15 ? m4 + 1 : m4;
    end
    step;
    mispredict = 1'b0;
  endtask
  task automatic wait_redir(input string tag, input int max);
    int n = 0;
    while (!a_redir && n < max) begin
      step;
      n++;
    end
    chk({tag, "_seen"}, a_redir, 1);
  endtask
  // every observed redirect must match the oldest accepted mispredict address
  always @(negedge clk) if (!rst && a_redir) begin
    if (sb.size() == 0) chk("unexp_redir", a_redir, 0);
    else begin
      e = sb.pop_front();
      chk("redir_addr", a_addr, e);
      chk("redir_addr4", b_addr, e);
      chk("redir_sync4", b_redir, 1);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step;
    step;
    outs("rst", 7'h00, 0);
    timeouts("rst", 0);
    chk("rst_redir", a_redir, 0);
    chk("rst_addr", a_addr, 0);
    cnts("rst");
    rst = 1'b0;
    step;
    done = 1'b1;
    mp(32'h0000_1234, 1);
    outs("s1_c1", 7'h7f, 1);
    step;
    outs("s1_c2", 7'h00, 1);
    chk("s1_c2_redir", a_redir, 0);
    step;
    chk("s1_c3_redir", a_redir, 1);
    outs("s1_c3", 7'h00, 1);
    step;
    outs("s1_c4", 7'h00, 0);
    chk("s1_c4_redir", a_redir, 0);
    chk("s1_addr_hold", a_addr, 32'h1234);
    cnts("s1");
    done = 1'b0;
    mp(32'h0000_2000, 1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("s2_wait_redir", a_redir, 0);
    end
    done = 1'b1;
    step;
    chk("s2_redir", a_redir, 1);
    timeouts("s2", 0);
    step;
    step;
    done = 1'b0;
    mp(32'h0000_3000, 1);
    for (int i = 2; i <= 16; i++) begin
      step;
      chk("s3_wait_redir", a_redir, 0);
    end
    timeouts("s3_early", 0);
    step;
    chk("s3_redir", a_redir, 1);
    timeouts("s3", 1);
    step;
    done = 1'b1;
    mp(32'h0000_4000, 1);
    wait_redir("s3b", 10);
    step;
    timeouts("s3b", 1);
    cnts("s3b");
    done = 1'b0;
    mp(32'h0000_5000, 1);
    step;
    mp(32'h0000_0088, 0);
    done = 1'b1;
    wait_redir("s4", 10);
    step;
    cnts("s4");
    mp(32'h0000_6000, 1);
    outs("s5_c1", 7'h7f, 1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      outs("s5_hold", 7'h7f, 1);
    end
    rdy = 1'b1;
    step;
    outs("s5_drain", 7'h00, 1);
    chk("s5_drain_redir", a_redir, 0);
    step;
    chk("s5_redir", a_redir, 1);
    step;
    done = 1'b0;
    mp(32'h0000_7000, 0);
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    m16 = 0;
    m4 = 0;
    outs("s6_rst", 7'h00, 0);
    timeouts("s6_rst", 0);
    chk("s6_rst_redir", a_redir, 0);
    chk("s6_rst_addr", a_addr, 0);
    cnts("s6_rst");
    step;
    outs("s6_post", 7'h00, 0);
    chk("s6_post_redir", a_redir, 0);
    done = 1'b1;
    for (int i = 0; i < 17; i++) begin
      mp(32'h100 + 32'(i) * 4, 1);
      wait_redir("s7", 10);
      step;
    end
    cnts("s7_sat");
    chk("s7_sat4", b_cnt, 15);
    chk("s7_cnt16", a_cnt, 17);
    step;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
